// File: rtl/tick_scheduler_pkg.sv
// Shared constants and helpers for the tick scheduler: period limits, default
// widths and the config-period clamp used when a request is captured.
package tick_pkg;

    localparam int MIN_PERIOD     = 2;
    localparam int DEFAULT_PERIOD = 2;
    localparam int CNT_W          = 32;
    localparam int MAX_CNT_W      = 64;

    typedef logic [MAX_CNT_W-1:0] wide_period_t;

    // Periods of 0 and 1 cannot produce a distinct tick, so they run as MIN_PERIOD
    function automatic wide_period_t clamp_period(input wide_period_t period);
        return (period < wide_period_t'(MIN_PERIOD)) ? wide_period_t'(MIN_PERIOD) : period;
    endfunction

    function automatic int chan_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/tick_scheduler_if.sv
// Configuration request channel of the tick scheduler: valid/ready handshake
// carrying the target channel, new period and run/stop flag.
interface tick_scheduler_if
    import tick_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = tick_pkg::CNT_W
) ();

    localparam int CH_W = chan_width(CHANNELS);

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_chan;
    logic [CNT_W-1:0] cfg_period;
    logic             cfg_enable;

    modport master (
        output cfg_valid,
        output cfg_chan,
        output cfg_period,
        output cfg_enable,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_chan,
        input  cfg_period,
        input  cfg_enable,
        output cfg_ready
    );

endinterface

// File: rtl/tick_scheduler_channel.sv
// One tick channel: a 0..period-1 counter with its period/enable registers and
// register-only decode of the tick enable and the debug phase square wave.
module tick_channel #(
    parameter int CNT_W          = tick_pkg::CNT_W,
    parameter int DEFAULT_PERIOD = tick_pkg::DEFAULT_PERIOD
) (
    input  logic             i_clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_loadPeriod,
    input  logic             i_loadEn,
    input  logic             i_sync,
    output logic             o_tick,
    output logic             o_phase,
    output logic             o_wrap
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_period;
    logic             r_en;
    logic             w_last;

    assign w_last = (r_count == (r_period - CNT_W'(1)));

    assign o_tick  = r_en & w_last;
    assign o_phase = r_en & (r_count >= (r_period >> 1));
    // o_wrap marks an edge where a new period can be loaded without cutting one short
    assign o_wrap  = w_last | ~r_en;

    // A load has priority over sync and wrap so the new period starts cleanly at zero
    always_ff @(posedge i_clk) begin
        if (rst) begin
            r_count  <= '0;
            r_period <= CNT_W'(DEFAULT_PERIOD);
            r_en     <= 1'b1;
        end else if (i_load) begin
            r_count  <= '0;
            r_period <= i_loadPeriod;
            r_en     <= i_loadEn;
        end else if (i_sync || !r_en || w_last) begin
            r_count  <= '0;
        end else begin
            r_count  <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/tick_scheduler.sv
// Multi-channel clock-enable scheduler: CHANNELS programmable tick channels with a
// single-slot shadow register that retunes one channel at its next period boundary.
module tick_scheduler
    import tick_pkg::*;
#(
    parameter int CHANNELS       = 4,
    parameter int CNT_W          = tick_pkg::CNT_W,
    parameter int DEFAULT_PERIOD = tick_pkg::DEFAULT_PERIOD
) (
    input  logic                i_clk,
    input  logic                rst,
    tick_scheduler_if.slave     cfg,
    input  logic                i_sync,
    output logic [CHANNELS-1:0] o_tick,
    output logic [CHANNELS-1:0] o_phase
);

    localparam int CH_W = chan_width(CHANNELS);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PENDING = 1'b1;

    logic [0:0]          r_state;
    logic [CH_W-1:0]     r_pendChan;
    logic [CNT_W-1:0]    r_pendPeriod;
    logic                r_pendEn;

    logic                w_accept;
    logic                w_targetWrap;
    logic                w_apply;
    logic [CHANNELS-1:0] w_wrap;
    logic [CHANNELS-1:0] w_load;

    assign cfg.cfg_ready = ~rst & (r_state == ST_IDLE);
    assign w_accept      = cfg.cfg_valid & cfg.cfg_ready;

    // A channel index beyond CHANNELS matches nothing and simply drains the slot
    always_comb begin
        w_targetWrap = 1'b1;
        for (int c = 0; c < CHANNELS; c++) begin
            if (r_pendChan == CH_W'(c)) begin
                w_targetWrap = w_wrap[c];
            end
        end
    end

    assign w_apply = (r_state == ST_PENDING) & (i_sync | w_targetWrap);

    always_ff @(posedge i_clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:    if (w_accept) r_state <= ST_PENDING;
                ST_PENDING: if (w_apply)  r_state <= ST_IDLE;
                default:                  r_state <= ST_IDLE;
            endcase
        end
    end

    // The shadow slot only changes on an accepted request, so it is stable while pending
    always_ff @(posedge i_clk) begin
        if (rst) begin
            r_pendChan   <= '0;
            r_pendPeriod <= CNT_W'(DEFAULT_PERIOD);
            r_pendEn     <= 1'b1;
        end else if (w_accept) begin
            r_pendChan   <= cfg.cfg_chan;
            r_pendPeriod <= CNT_W'(clamp_period(wide_period_t'(cfg.cfg_period)));
            r_pendEn     <= cfg.cfg_enable;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        assign w_load[g] = w_apply & (r_pendChan == CH_W'(g));

        tick_channel #(
            .CNT_W          (CNT_W),
            .DEFAULT_PERIOD (DEFAULT_PERIOD)
        ) u_channel (
            .i_clk        (i_clk),
            .rst          (rst),
            .i_load       (w_load[g]),
            .i_loadPeriod (r_pendPeriod),
            .i_loadEn     (r_pendEn),
            .i_sync       (i_sync),
            .o_tick       (o_tick[g]),
            .o_phase      (o_phase[g]),
            .o_wrap       (w_wrap[g])
        );
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// Self-checking bench for tick_scheduler: directed vector table, hand-written
// corner sequences and random traffic, all compared against a cycle-level model.
module tb_tick_scheduler;

    localparam int NCH = 4;
    localparam int CW  = 4;
    localparam int DEF = 2;

    typedef struct {
        int rst;
        int valid;
        int chan;
        int period;
        int en;
        int sync;
        int expTick;
        int expPhase;
        int expReady;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           sync;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] phase;

    int nChecks = 0;
    int nErrors = 0;

    int mPos[NCH];
    int mPer[NCH];
    bit mEn[NCH];
    bit mPend;
    int mChan;
    int mPeriod;
    bit mEnable;
    bit mValid = 1'b0;

    int   firstSeen[NCH];
    vec_t vecs[14];

    always #5 clk = ~clk;

    tick_scheduler_if #(.CHANNELS(NCH), .CNT_W(CW)) cfgIf ();

    tick_scheduler #(
        .CHANNELS       (NCH),
        .CNT_W          (CW),
        .DEFAULT_PERIOD (DEF)
    ) dut (
        .i_clk   (clk),
        .rst     (rst),
        .cfg     (cfgIf),
        .i_sync  (sync),
        .o_tick  (tick),
        .o_phase (phase)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual !== expected) begin
            nErrors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int modelTick();
        int m = 0;
        for (int c = 0; c < NCH; c++)
            if (mEn[c] && mPos[c] == mPer[c] - 1) m |= (1 << c);
        return m;
    endfunction

    function automatic int modelPhase();
        int m = 0;
        for (int c = 0; c < NCH; c++)
            if (mEn[c] && mPos[c] >= mPer[c] / 2) m |= (1 << c);
        return m;
    endfunction

    // Model of one clock edge, written from the channel rules with modulo arithmetic
    task automatic modelEdge();
        bit acc;
        bit app;
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                mPos[c] = 0;
                mPer[c] = DEF;
                mEn[c]  = 1'b1;
            end
            mPend  = 1'b0;
            mValid = 1'b1;
        end else begin
            acc = cfgIf.cfg_valid && !mPend;
            app = mPend && (sync || !mEn[mChan] || mPos[mChan] == mPer[mChan] - 1);
            for (int c = 0; c < NCH; c++) begin
                if (sync || !mEn[c]) mPos[c] = 0;
                else                 mPos[c] = (mPos[c] + 1) % mPer[c];
            end
            if (app) begin
                mPer[mChan] = mPeriod;
                mEn[mChan]  = mEnable;
                mPos[mChan] = 0;
                mPend       = 1'b0;
            end
            if (acc) begin
                mPend   = 1'b1;
                mChan   = int'(cfgIf.cfg_chan);
                mPeriod = (int'(cfgIf.cfg_period) < 2) ? 2 : int'(cfgIf.cfg_period);
                mEnable = cfgIf.cfg_enable;
            end
        end
    endtask

    task automatic checkModel();
        checkOutput("ready", int'(cfgIf.cfg_ready), int'(rst == 1'b0 && !mPend));
        if (mValid) begin
            checkOutput("tick", int'(tick), modelTick());
            checkOutput("phase", int'(phase), modelPhase());
        end
    endtask

    task automatic applyStimulus(input int r, input int v, input int ch, input int p, input int e, input int s);
        rst              = 1'(r);
        cfgIf.cfg_valid  = 1'(v);
        cfgIf.cfg_chan   = 2'(ch);
        cfgIf.cfg_period = 4'(p);
        cfgIf.cfg_enable = 1'(e);
        sync             = 1'(s);
        #1;
        checkModel();
    endtask

    task automatic advance();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        advance();
    endtask

    task automatic sendCfg(input int ch, input int p, input int e);
        int guard = 0;
        while (mPend && guard < 40) begin idle(); guard++; end
        applyStimulus(0, 1, ch, p, e, 0);
        advance();
        guard = 0;
        while (mPend && guard < 40) begin idle(); guard++; end
    endtask

    task automatic firstTicks(input int limit);
        for (int c = 0; c < NCH; c++) firstSeen[c] = -1;
        for (int j = 0; j < limit; j++) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
            for (int c = 0; c < NCH; c++)
                if (tick[c] && firstSeen[c] < 0) firstSeen[c] = j;
            advance();
        end
    endtask

    task automatic measureGap(input int ch, input int expGap, input string name);
        int t0 = -1;
        int t1 = -1;
        for (int j = 0; j < 60 && t1 < 0; j++) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
            if (tick[ch]) begin
                if (t0 < 0) t0 = j;
                else        t1 = j;
            end
            advance();
        end
        checkOutput(name, (t1 < 0) ? -1 : t1 - t0, expGap);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", nErrors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{0, 0, 0, 0, 0, 0, 'b0000, 'b0000, 1};
        vecs[1]  = '{0, 0, 0, 0, 0, 0, 'b1111, 'b1111, 1};
        vecs[2]  = '{0, 1, 1, 5, 1, 0, 'b0000, 'b0000, 1};
        vecs[3]  = '{0, 0, 0, 0, 0, 0, 'b1111, 'b1111, 0};
        vecs[4]  = '{0, 0, 0, 0, 0, 0, 'b0000, 'b0000, 1};
        vecs[5]  = '{0, 0, 0, 0, 0, 0, 'b1101, 'b1101, 1};
        vecs[6]  = '{0, 0, 0, 0, 0, 0, 'b0000, 'b0010, 1};
        vecs[7]  = '{0, 0, 0, 0, 0, 0, 'b1101, 'b1111, 1};
        vecs[8]  = '{0, 0, 0, 0, 0, 0, 'b0010, 'b0010, 1};
        vecs[9]  = '{0, 0, 0, 0, 0, 0, 'b1101, 'b1101, 1};
        vecs[10] = '{0, 0, 0, 0, 0, 0, 'b0000, 'b0000, 1};
        vecs[11] = '{0, 0, 0, 0, 0, 0, 'b1101, 'b1111, 1};
        vecs[12] = '{0, 0, 0, 0, 0, 0, 'b0000, 'b0010, 1};
        vecs[13] = '{0, 0, 0, 0, 0, 0, 'b1111, 'b1111, 1};

        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("ready during rst", int'(cfgIf.cfg_ready), 0);
        advance();
        applyStimulus(1, 0, 0, 0, 0, 0);
        advance();

        // Defaults after reset, then ch1 retuned to period 5 at count 0
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].chan, vecs[i].period, vecs[i].en, vecs[i].sync);
            checkOutput($sformatf("vec%0d tick", i), int'(tick), vecs[i].expTick);
            checkOutput($sformatf("vec%0d phase", i), int'(phase), vecs[i].expPhase);
            checkOutput($sformatf("vec%0d ready", i), int'(cfgIf.cfg_ready), vecs[i].expReady);
            advance();
        end

        sendCfg(2, 2, 0);
        for (int j = 0; j < 6; j++) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
            checkOutput("ch2 off tick", int'(tick[2]), 0);
            checkOutput("ch2 off phase", int'(phase[2]), 0);
            advance();
        end
        sendCfg(2, 3, 1);
        firstTicks(6);
        checkOutput("ch2 first tick after enable", firstSeen[2], 2);

        sendCfg(0, 0, 1);
        measureGap(0, 2, "period0 clamp gap");
        sendCfg(0, 1, 1);
        measureGap(0, 2, "period1 clamp gap");
        sendCfg(0, 15, 1);
        measureGap(0, 15, "period max gap");

        sendCfg(0, 3, 1);
        sendCfg(1, 4, 1);
        sendCfg(2, 5, 1);
        sendCfg(3, 7, 1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        advance();
        firstTicks(8);
        checkOutput("sync ch0 first", firstSeen[0], 2);
        checkOutput("sync ch1 first", firstSeen[1], 3);
        checkOutput("sync ch2 first", firstSeen[2], 4);
        checkOutput("sync ch3 first", firstSeen[3], 6);

        while (mPend) idle();
        applyStimulus(0, 1, 3, 2, 1, 1);
        advance();
        firstTicks(10);
        checkOutput("sync+cfg ch0 first", firstSeen[0], 2);
        checkOutput("sync+cfg ch3 old period", firstSeen[3], 6);
        measureGap(3, 2, "sync+cfg ch3 new gap");

        sendCfg(3, 9, 1);
        applyStimulus(0, 1, 3, 4, 1, 0);
        advance();
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("ready in mid rst", int'(cfgIf.cfg_ready), 0);
        advance();
        applyStimulus(1, 0, 0, 0, 0, 0);
        advance();
        idle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("ready after rst", int'(cfgIf.cfg_ready), 1);
        advance();
        measureGap(3, DEF, "ch3 default after rst");

        for (int i = 0; i < 1500; i++) begin
            applyStimulus(($urandom_range(0, 299) == 0) ? 1 : 0,
                          ($urandom_range(0, 2) == 0) ? 1 : 0,
                          int'($urandom_range(0, NCH - 1)),
                          int'($urandom_range(0, 15)),
                          ($urandom_range(0, 3) != 0) ? 1 : 0,
                          ($urandom_range(0, 39) == 0) ? 1 : 0);
            advance();
        end

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
